// File: rtl/seq_det_fsm_if.sv
// Serial detector bundle: the stream bit from the source and the detect pulse,
// match count and FSM state returned by the detector.
interface seq_det_fsm_if;
  logic       x;
  logic       y;
  logic [7:0] match_cnt;
  logic [2:0] state_dbg;

  modport master (output x, input  y, match_cnt, state_dbg);
  modport slave  (input  x, output y, match_cnt, state_dbg);
endinterface

// File: rtl/seq_det_fsm.sv
// Serial 1-0-0-1-0 detector with registered pulse and saturating match counter.
// Defining SEQ_DET_OVERLAP_EN makes a match reuse its trailing "10" (overlapping detection).
module seq_det_fsm (
  input  logic          Clk,
  input  logic          rst,
  seq_det_fsm_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S1    = 3'd1,
    S10   = 3'd2,
    S100  = 3'd3,
    S1001 = 3'd4
  } state_e;

`ifdef SEQ_DET_OVERLAP_EN
  localparam state_e MATCH_NEXT = S10;
`else
  localparam state_e MATCH_NEXT = IDLE;
`endif

  state_e     state_q, state_d;
  logic       y_q, y_d;
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    state_d = IDLE;
    y_d     = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:  state_d = bus.x ? S1    : IDLE;
      S1:    state_d = bus.x ? S1    : S10;
      S10:   state_d = bus.x ? S1    : S100;
      S100:  state_d = bus.x ? S1001 : IDLE;
      S1001: begin
        if (bus.x) begin
          state_d = S1;
        end else begin
          // Final 0 completes the pattern; the counter sticks at 255.
          state_d = MATCH_NEXT;
          y_d     = 1'b1;
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.y         = y_q;
  assign bus.match_cnt = cnt_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_seq_det_fsm.sv
// Randomized scoreboard bench for seq_det_fsm against a string-matching reference model.
module tb_seq_det_fsm;

  logic Clk = 1'b0;
  logic rst = 1'b1;

  seq_det_fsm_if bus ();

  seq_det_fsm dut (
    .Clk (Clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  logic [8:0] exp_q[$];
  int         n_checks  = 0;
  int         n_pass    = 0;
  int         pulse_cnt = 0;

  // Reference model: last five accepted bits plus how many are valid since the
  // last restart point (reset, or a consumed match in the non-overlapping build).
  logic [4:0] hist  = 5'd0;
  int         valid = 0;
  int         mcnt  = 0;

`ifdef SEQ_DET_OVERLAP_EN
  localparam int PULSES_PER_PERIOD = 2;
`else
  localparam int PULSES_PER_PERIOD = 1;
`endif

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got y=%0b cnt=%0d, expected y=%0b cnt=%0d",
                  name, act[8], act[7:0], exp[8], exp[7:0]);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic model_step(input logic b, output logic hit);
    hist = {hist[3:0], b};
    if (valid < 5) valid++;
    hit = (valid >= 5) && (hist == 5'b10010);
    if (hit) begin
      if (mcnt < 255) mcnt++;
`ifndef SEQ_DET_OVERLAP_EN
      valid = 0;
`endif
    end
  endtask

  // One clock of stimulus: bit b with reset level r, expected response queued.
  task automatic drive(input logic b, input logic r);
    logic hit;
    @(negedge Clk);
    bus.x = b;
    rst   = r;
    if (r) begin
      valid = 0;
      mcnt  = 0;
      exp_q.push_back(9'd0);
      #1;
      check("async_reset", {bus.y, bus.match_cnt}, 9'd0);
    end else begin
      model_step(b, hit);
      exp_q.push_back({hit, 8'(mcnt)});
    end
  endtask

  task automatic drive_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) drive(bits[i], 1'b0);
  endtask

  // Monitor: one registered response per clock, compared just after the edge.
  initial begin
    logic [8:0] e;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle", {bus.y, bus.match_cnt}, e);
        if (bus.y) pulse_cnt++;
      end
    end
  end

  initial begin
    logic [23:0] period;
    int          wait_cnt;
    period = 24'b0000_1100_1101_0001_0010_0100;
    bus.x  = 1'b0;

    // Held in reset with x toggling.
    for (int i = 0; i < 10; i++) drive(1'($urandom_range(0, 1)), 1'b1);

    // Single match, then a few idle zeros.
    drive_bits(32'b10010, 5);
    drive_bits(32'b000, 3);

    // Near misses.
    drive_bits(32'b100010011, 9);

    // Reset mid-pattern discards the partial match.
    drive(1'b0, 1'b1);
    drive_bits(32'b1001, 4);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    drive_bits(32'b00, 2);

    // Periodic stream.
    drive(1'b0, 1'b1);
    @(posedge Clk); #2;
    pulse_cnt = 0;
    for (int p = 0; p < 4; p++) drive_bits(32'(period), 24);
    @(posedge Clk); #2;
    check_int("stream_pulses", pulse_cnt, 4 * PULSES_PER_PERIOD);

    // Random stream with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) drive(1'b0, 1'b1);
      else if ($urandom_range(0, 3) == 0) drive_bits(32'b10010, 5);
      else drive(1'($urandom_range(0, 1)), 1'b0);
    end

    // Saturation: 300 back-to-back matches.
    drive(1'b0, 1'b1);
    @(posedge Clk); #2;
    pulse_cnt = 0;
    for (int i = 0; i < 300; i++) drive_bits(32'b10010, 5);
    @(posedge Clk); #2;
    check_int("sat_pulses", pulse_cnt, 300);
    check_int("sat_count", int'(bus.match_cnt), 255);

    // Reset must clear a saturated counter immediately.
    drive(1'b0, 1'b1);
    drive_bits(32'b000, 3);

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(posedge Clk);
      wait_cnt++;
    end
    #2;
    check_int("drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
